// File: rtl/cr_kme_stall_tx_if.sv
// Command and stall-FIFO write-side bundle for cr_kme_stall_tx.
// Optional parity signals exist only when CR_KME_STALL_TX_PARITY_EN is defined.
interface cr_kme_stall_tx_if #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned NUM_BEATS = 4,
  parameter int unsigned LEN_W     = 2
);
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [DATA_SIZE*NUM_BEATS-1:0] cmd_data;
  logic [LEN_W-1:0]               cmd_len;
  logic                           fifo_in_stall;
  logic [DATA_SIZE-1:0]           fifo_in;
  logic                           fifo_in_valid;
  logic                           fifo_in_sop;
  logic                           fifo_in_eop;
`ifdef CR_KME_STALL_TX_PARITY_EN
  logic                           cmd_par_chk;
  logic                           fifo_in_par;

  modport master (
    output cmd_valid, cmd_data, cmd_len, fifo_in_stall, cmd_par_chk,
    input  cmd_ready, fifo_in, fifo_in_valid, fifo_in_sop, fifo_in_eop, fifo_in_par
  );
  modport slave (
    input  cmd_valid, cmd_data, cmd_len, fifo_in_stall, cmd_par_chk,
    output cmd_ready, fifo_in, fifo_in_valid, fifo_in_sop, fifo_in_eop, fifo_in_par
  );
`else
  modport master (
    output cmd_valid, cmd_data, cmd_len, fifo_in_stall,
    input  cmd_ready, fifo_in, fifo_in_valid, fifo_in_sop, fifo_in_eop
  );
  modport slave (
    input  cmd_valid, cmd_data, cmd_len, fifo_in_stall,
    output cmd_ready, fifo_in, fifo_in_valid, fifo_in_sop, fifo_in_eop
  );
`endif
endinterface

// File: rtl/cr_kme_stall_tx.sv
// Serialises one wide command into DATA_SIZE-bit beats for a stall-protocol FIFO.
// Optional parity feature: define CR_KME_STALL_TX_PARITY_EN.
module cr_kme_stall_tx #(
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned NUM_BEATS = 4,
  parameter int unsigned LEN_W     = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cr_kme_stall_tx_if.slave     tx,
  input  logic                 fifo_overflow,
  output logic                 busy,
  output logic                 err_len,
  output logic                 err_ovf,
`ifdef CR_KME_STALL_TX_PARITY_EN
  output logic                 err_par,
`endif
  output logic [CNT_W-1:0]     beats_sent
);

  localparam int unsigned W = DATA_SIZE * NUM_BEATS;
  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(NUM_BEATS - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e           state_q;
  logic [W-1:0]     shreg_q;
  logic [LEN_W-1:0] cnt_q;
  logic             first_q;
  logic             ready_q;
  logic             beat;

  // Write strobe follows stall combinationally so no beat is issued into a full FIFO.
  assign beat             = (state_q == StSend) && !tx.fifo_in_stall;
  assign tx.fifo_in_valid = beat;
  assign tx.fifo_in_sop   = beat && first_q;
  assign tx.fifo_in_eop   = beat && (cnt_q == '0);
  assign tx.fifo_in       = shreg_q[DATA_SIZE-1:0];
  assign tx.cmd_ready     = ready_q;
`ifdef CR_KME_STALL_TX_PARITY_EN
  assign tx.fifo_in_par   = ^shreg_q[DATA_SIZE-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      ready_q    <= 1'b1;
      busy       <= 1'b0;
      err_len    <= 1'b0;
      err_ovf    <= 1'b0;
      beats_sent <= '0;
`ifdef CR_KME_STALL_TX_PARITY_EN
      err_par    <= 1'b0;
`endif
    end else begin
      if (fifo_overflow) begin
        err_ovf <= 1'b1;
      end
      if (beat) begin
        beats_sent <= beats_sent + CNT_W'(1);
      end
      case (state_q)
        StIdle: begin
          if (tx.cmd_valid && ready_q) begin
            shreg_q <= tx.cmd_data;
            first_q <= 1'b1;
            ready_q <= 1'b0;
            busy    <= 1'b1;
            state_q <= StSend;
            // Over-long commands are truncated to the beats the payload can hold.
            if (tx.cmd_len > MaxLen) begin
              cnt_q   <= MaxLen;
              err_len <= 1'b1;
            end else begin
              cnt_q <= tx.cmd_len;
            end
`ifdef CR_KME_STALL_TX_PARITY_EN
            if ((^tx.cmd_data) != tx.cmd_par_chk) begin
              err_par <= 1'b1;
            end
`endif
          end
        end
        StSend: begin
          if (beat) begin
            shreg_q <= shreg_q >> DATA_SIZE;
            first_q <= 1'b0;
            if (cnt_q == '0) begin
              state_q <= StIdle;
              ready_q <= 1'b1;
              busy    <= 1'b0;
            end else begin
              cnt_q <= cnt_q - LEN_W'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
